vote_session_ctrl: RTL

//  Central controller of the voting machine. Sits behind the per-candidate button

---
 rtl/vote_session_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vote_session_ctrl.sv
// Voting machine session controller: round-robin arbitration of debounced vote pulses,
// per-voter lockout, saturating per-candidate tallies and a result read-out mode.
module vote_session_ctrl #(
  parameter int N_CAND      = 4,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              mode,
  input  logic [N_CAND-1:0]                 valid_vote,
  input  logic [$clog2(N_CAND)-1:0]         sel,
  input  logic                              clear_counts,
  output logic                              vote_ack,
  output logic                              conflict,
  output logic [N_CAND-1:0]                 granted_led,
  output logic                              busy,
  output logic [CNT_W-1:0]                  result_count,
  output logic [CNT_W+$clog2(N_CAND)-1:0]   total_votes,
  output logic                              sat_flag
);

  localparam int PTR_W  = $clog2(N_CAND);
  localparam int IDX_W  = PTR_W + 1;
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [IDX_W-1:0]  N_CAND_W  = IDX_W'(N_CAND);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(N_CAND - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, LOCK, RESULT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   tally [N_CAND];
  logic [PTR_W-1:0]   rr_ptr;
  logic [LOCK_W-1:0]  lock_cnt;

  logic [IDX_W-1:0]   cand;
  logic [PTR_W-1:0]   grant_idx;
  logic [N_CAND-1:0]  grant_onehot;
  logic               multi_req;
  logic [PTR_W-1:0]   rr_next;
  logic [CNT_W-1:0]   sel_count;

  // Search upward from rr_ptr with wrap; the first requester found wins.
  always_comb begin
    cand         = '0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int k = N_CAND - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + IDX_W'(k);
      if (cand >= N_CAND_W) cand = cand - N_CAND_W;
      if (valid_vote[cand[PTR_W-1:0]]) grant_idx = cand[PTR_W-1:0];
    end
    grant_onehot[grant_idx] = 1'b1;
  end

  always_comb begin
    multi_req = ($countones(valid_vote) > 1);
    rr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    sel_count = '0;
    if ({1'b0, sel} < N_CAND_W) sel_count = tally[sel];
  end

  // Session FSM; every output is a register written here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      lock_cnt     <= '0;
      vote_ack     <= 1'b0;
      conflict     <= 1'b0;
      granted_led  <= '0;
      busy         <= 1'b0;
      result_count <= '0;
      total_votes  <= '0;
      sat_flag     <= 1'b0;
      for (int i = 0; i < N_CAND; i++) tally[i] <= '0;
    end else begin
      vote_ack <= 1'b0;
      conflict <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mode) begin
            state        <= RESULT;
            result_count <= sel_count;
          end else if (|valid_vote) begin
            state       <= LOCK;
            vote_ack    <= 1'b1;
            conflict    <= multi_req;
            granted_led <= grant_onehot;
            busy        <= 1'b1;
            lock_cnt    <= LOCK_LOAD;
            rr_ptr      <= rr_next;
            // A vote on a full tally is still acknowledged but not counted.
            if (tally[grant_idx] == CNT_MAX) begin
              sat_flag <= 1'b1;
            end else begin
              tally[grant_idx] <= tally[grant_idx] + 1'b1;
              total_votes      <= total_votes + 1'b1;
              if (tally[grant_idx] == CNT_MAX - 1'b1) sat_flag <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (lock_cnt == '0) begin
            state       <= IDLE;
            busy        <= 1'b0;
            granted_led <= '0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        RESULT: begin
          if (clear_counts) begin
            total_votes <= '0;
            for (int i = 0; i < N_CAND; i++) tally[i] <= '0;
          end
          if (!mode) begin
            state        <= IDLE;
            result_count <= '0;
          end else begin
            result_count <= sel_count;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
